// File: rtl/booth_pkg.sv
// Shared definitions for the Booth-product MAC accumulator.
//   PROD_W    : width of the signed product from the 4x4 Booth multiplier
//   DEF_ACC_W : default accumulator width
//   DEF_LEN   : default number of products per frame
//   CNT_W     : width of the per-frame product counter
//   state_t   : frame FSM state encoding
package booth_pkg;

    localparam int unsigned PROD_W    = 8;
    localparam int unsigned DEF_ACC_W = 12;
    localparam int unsigned DEF_LEN   = 4;
    localparam int unsigned CNT_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/booth_sat_add.sv
// Saturating signed adder: acc + sign-extended prod, clamped to the ACC_W range.
//   acc     : current signed accumulator value
//   prod    : signed product to add
//   sum     : clamped signed result
//   clamped : high when the exact sum fell outside the ACC_W range
module booth_sat_add
    import booth_pkg::*;
#(
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [PROD_W-1:0] prod,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     clamped
);

    localparam int unsigned EXT_W = ACC_W + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [EXT_W-1:0] w_ext_acc;
    logic signed [EXT_W-1:0] w_ext_prod;
    logic signed [EXT_W-1:0] w_sum;

    // One guard bit is enough: |acc| + |prod| < 2^ACC_W for ACC_W >= 9.
    assign w_ext_acc  = {acc[ACC_W-1], acc};
    assign w_ext_prod = {{(EXT_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign w_sum      = w_ext_acc + w_ext_prod;

    // Overflow shows as a disagreement between the guard bit and the ACC_W sign bit.
    always_comb begin
        sum     = w_sum[ACC_W-1:0];
        clamped = 1'b0;
        if (w_sum[EXT_W-1] != w_sum[ACC_W-1]) begin
            clamped = 1'b1;
            sum     = w_sum[EXT_W-1] ? ACC_MIN : ACC_MAX;
        end
    end

endmodule

// File: rtl/booth_mac_accum.sv
// Frame accumulator for Booth multiplier products with saturating add.
//   clk, rst_n            : clock, asynchronous active-low reset
//   ena                   : enable; low blocks input acceptance
//   clr                   : synchronous frame abort, highest priority
//   in_valid/in_ready     : product input handshake, in_prod is the product
//   out_valid/out_ready   : frame result handshake
//   out_acc, out_sat      : frame sum and sticky saturation flag (0 outside HOLD)
//   busy                  : frame in progress or result pending
module booth_mac_accum
    import booth_pkg::*;
#(
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned LEN   = DEF_LEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_prod,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_acc,
    output logic                     out_sat,
    output logic                     busy
);

    localparam logic [CNT_W-1:0] LEN_CNT = CNT_W'(LEN);

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_sat;
    logic                     r_out_valid;
    logic signed [ACC_W-1:0]  r_out_acc;
    logic                     r_out_sat;
    logic                     r_busy;

    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic                     w_sat_nxt;
    logic                     w_out_valid_nxt;
    logic signed [ACC_W-1:0]  w_out_acc_nxt;
    logic                     w_out_sat_nxt;

    logic                     w_in_ready;
    logic                     w_accept;
    logic [CNT_W-1:0]         w_cnt_inc;
    logic signed [ACC_W-1:0]  w_sum;
    logic                     w_clamped;
    logic                     w_sat_acc;

    booth_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc     (r_acc),
        .prod    (in_prod),
        .sum     (w_sum),
        .clamped (w_clamped)
    );

    // Ready depends only on registered state and the ena/clr inputs, never on out_ready.
    assign w_in_ready = rst_n & ena & (r_state != ST_HOLD) & ~clr;
    assign w_accept   = in_valid & w_in_ready;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_sat_acc  = r_sat | w_clamped;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_sat   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_acc       <= w_acc_nxt;
            r_sat       <= w_sat_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_acc   <= w_out_acc_nxt;
            r_out_sat   <= w_out_sat_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_acc_nxt       = r_acc;
        w_sat_nxt       = r_sat;
        w_out_valid_nxt = r_out_valid;
        w_out_acc_nxt   = r_out_acc;
        w_out_sat_nxt   = r_out_sat;

        if (clr) begin
            w_state_nxt     = ST_IDLE;
            w_cnt_nxt       = '0;
            w_acc_nxt       = '0;
            w_sat_nxt       = 1'b0;
            w_out_valid_nxt = 1'b0;
            w_out_acc_nxt   = '0;
            w_out_sat_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    if (w_accept) begin
                        w_acc_nxt = w_sum;
                        w_sat_nxt = w_sat_acc;
                        if (w_cnt_inc == LEN_CNT) begin
                            // Frame complete: snapshot the result into the output registers.
                            w_state_nxt     = ST_HOLD;
                            w_cnt_nxt       = '0;
                            w_out_valid_nxt = 1'b1;
                            w_out_acc_nxt   = w_sum;
                            w_out_sat_nxt   = w_sat_acc;
                        end else begin
                            w_state_nxt = ST_ACCUM;
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        w_state_nxt     = ST_IDLE;
                        w_acc_nxt       = '0;
                        w_sat_nxt       = 1'b0;
                        w_out_valid_nxt = 1'b0;
                        w_out_acc_nxt   = '0;
                        w_out_sat_nxt   = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt     = ST_IDLE;
                    w_cnt_nxt       = '0;
                    w_acc_nxt       = '0;
                    w_sat_nxt       = 1'b0;
                    w_out_valid_nxt = 1'b0;
                    w_out_acc_nxt   = '0;
                    w_out_sat_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_sat   = r_out_sat;
    assign busy      = r_busy;

endmodule

// File: doc/booth_mac_accum.md
# booth_mac_accum

Downstream consumer of the 4x4 signed Booth multiplier. It accepts the 8-bit signed product through a valid/ready handshake and accumulates a fixed-length frame of products into a saturating signed accumulator. It then presents the frame result, with a sticky saturation flag, on a second valid/ready handshake. The block turns the combinational multiplier into a dot-product / MAC datapath.

## Interface
- `ACC_W`, default 12: accumulator width, signed two's complement; legal range 9..16.
- `LEN`, default 4: number of products per frame; legal range 1..63.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `ena`  input  1  design enable; low freezes the input side.
- `clr`  input  1  synchronous frame abort/clear.
- `in_valid`  input  1  `in_prod` is valid.
- `in_ready`  output  1  block can accept a product this cycle.
- `in_prod`  input  8  signed product from the multiplier.
- `out_valid`  output  1  frame result available.
- `out_ready`  input  1  consumer takes the result.
- `out_acc`  output  ACC_W  signed frame sum.
- `out_sat`  output  1  at least one clamp occurred in this frame.
- `busy`  output  1  frame in progress (count > 0 or result pending).

## Operation
- **States:**
  - IDLE: `cnt`=0, `acc`=0.
  - ACCUM: 0 < `cnt` < `LEN`.
  - HOLD: result pending.
- **Input handshake:**
  - `in_ready` = `ena` & (state != HOLD) & !`clr`. It is decoded from registered state only, with no combinational path from `out_ready`.
  - A product is accepted on a rising edge where `in_valid` & `in_ready`.
- **Accumulate:**
  - `in_prod` is sign-extended to ACC_W+1 bits and added to `acc`.
  - The sum is clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Clamping is applied per add, not at frame end.
  - Any clamp sets `sat`. `sat` is sticky until the frame is consumed or cleared.
- **Counting:**
  - `cnt` (6 bits) increments on each accept.
  - When the accept makes `cnt`=`LEN`, the next state is HOLD and `cnt` resets to 0.
  - IDLE→ACCUM on the first accept when `LEN`>1. IDLE→HOLD directly when `LEN`=1.
- **HOLD:**
  - `out_valid`=1. `out_acc` and `out_sat` stay stable until `out_valid` & `out_ready`.
  - On that output transfer, the next state is IDLE with `acc`=0 and `sat`=0.
  - No input is accepted in the transfer cycle.
  - The output handshake is independent of `ena`.
- **clr:**
  - Highest priority of all synchronous actions.
  - Next state is IDLE; `acc`, `cnt`, `sat` and `out_valid` all go to 0.
  - This applies in any state, including HOLD, where the pending result is discarded.
  - A product presented in the `clr` cycle is not accepted.
- **ena low:** `in_ready`=0. `acc` and `cnt` hold their values.
- **busy:** 1 in ACCUM and HOLD.
- **Outputs outside HOLD:** `out_acc` and `out_sat` read 0 when `out_valid`=0.

## Timing
- Reset, asynchronous assert with synchronous effect of deassertion: state IDLE, `acc`=0, `cnt`=0, `sat`=0. Outputs: `out_valid`=0, `in_ready`=0 while `rst_n` is low, `out_acc`=0, `out_sat`=0, `busy`=0.
- Accumulate latency: an accepted product is reflected in `acc` on the next edge.
- Result latency: `out_valid` rises one cycle after the `LEN`-th accept. `out_acc` includes that product.
- Throughput: `LEN` accept cycles plus a minimum of 1 HOLD cycle per frame. Back-to-back frames therefore have a one-cycle input bubble.
- Reset asserted mid-frame: the partial sum is lost and outputs go to reset values immediately.

## Structure
- **Package `booth_pkg`:**
  - State encoding: IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2.
  - Default `ACC_W` and `LEN`.
  - Product width constant `PROD_W`=8.
- **Sub-module `booth_sat_add`:**
  - Combinational, parameterised by `ACC_W`.
  - Inputs: `acc`, `prod`. Outputs: `sum`, `clamped`.
  - It is the only arithmetic in the block.
- **Top:** holds the FSM, counter and registers.

## Test plan
- **Basic frame:** `LEN`=4, `ACC_W`=12; accept 10, 20, -5, 7 back-to-back with `out_ready`=1.
  - `out_valid` one cycle after the 4th accept, `out_acc`=32, `out_sat`=0.
  - Then IDLE with `acc`=0.
- **Positive saturation:** `LEN`=40; 40 products of 64.
  - `out_acc`=2047, `out_sat`=1.
  - The next frame of 4x1 gives `out_acc`=4, `out_sat`=0.
- **Negative saturation:** `LEN`=40; 40 products of -56 → `out_acc`=-2048, `out_sat`=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles with `in_valid`=1.
  - `in_ready`=0 and `out_acc` is stable throughout.
  - On `out_ready`=1: exactly one transfer, and no product accepted that cycle.
- **Gaps and ena:** `in_valid` toggling plus `ena` low for 3 cycles mid-frame.
  - `cnt`/`acc` frozen while `ena` is low; the final sum equals the sum of accepted products only.
- **Aborts:**
  - `clr` pulsed after 2 of 4 products → IDLE, `acc`=0, no `out_valid`.
  - `clr` during HOLD → `out_valid` drops next cycle.
  - `rst_n` low mid-frame → all outputs 0 immediately.
